// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with optional parity, 1/2 stop bits and a ready/valid output
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_trigger,
  input  logic                 raw_data,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_nx;
  logic sync1, line, armed, v0, v1, par_acc, pe_q, fe_q, done;
  logic decide, wrap, vote, fe_frame, accept;
  logic [1:0] warm;
  logic [TW-1:0] tick;
  logic [3:0] cnt;
  logic [DATA_BITS-1:0] shreg;
  assign decide   = sample_trigger && state != S_IDLE && tick == TW'(M + 1);
  assign wrap     = sample_trigger && tick == TW'(OVERSAMPLE - 1);
  assign vote     = (v0 & v1) | (v0 & line) | (v1 & line);
  assign fe_frame = fe_q | ~vote;
  assign accept   = data_valid & data_ready;
  always_comb begin
    state_nx = state;
    done = 1'b0;
    case (state)
      S_IDLE:   if (sample_trigger && armed && !line) state_nx = S_START;
      S_START:  if (decide && vote) state_nx = S_IDLE; else if (wrap) state_nx = S_DATA;
      S_DATA:   if (wrap && cnt == 4'(DATA_BITS)) state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) state_nx = S_STOP;
      S_STOP:   if (decide && cnt == 4'(STOP_BITS - 1)) begin
        state_nx = S_IDLE;
        done = 1'b1;
      end
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1       <= 1'b1;
      line        <= 1'b1;
      warm        <= '0;
      armed       <= 1'b0;
      state       <= S_IDLE;
      tick        <= '0;
      cnt         <= '0;
      v0          <= 1'b1;
      v1          <= 1'b1;
      shreg       <= '0;
      par_acc     <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync1 <= raw_data;
      line  <= sync1;
      warm  <= {warm[0], 1'b1};
      // start detection re-arms only on a high line that came through the synchroniser after reset or a break
      if (done && fe_frame) armed <= 1'b0;
      else if (warm[1] && line) armed <= 1'b1;
      state <= state_nx;
      tick  <= (state == S_IDLE || wrap) ? '0 : sample_trigger ? tick + 1'b1 : tick;
      cnt   <= (state_nx != state) ? '0 : (decide && (state == S_DATA || state == S_STOP)) ? cnt + 1'b1 : cnt;
      if (sample_trigger && tick == TW'(M - 1)) v0 <= line;
      if (sample_trigger && tick == TW'(M)) v1 <= line;
      if (decide && state == S_DATA) begin
        shreg   <= {vote, shreg[DATA_BITS-1:1]};
        par_acc <= par_acc ^ vote;
      end else if (state == S_IDLE) par_acc <= 1'b0;
      if (state == S_IDLE) pe_q <= 1'b0;
      else if (decide && state == S_PARITY) pe_q <= par_acc ^ vote ^ (PARITY == 1);
      if (state == S_IDLE) fe_q <= 1'b0;
      else if (decide && state == S_STOP) fe_q <= fe_frame;
      if (done && (!data_valid || data_ready)) begin
        data        <= shreg;
        parity_err  <= pe_q;
        framing_err <= fe_frame;
        data_valid  <= 1'b1;
      end else if (accept) data_valid <= 1'b0;
      if (done && data_valid && !data_ready) overrun <= 1'b1;
      else if (accept) overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations driven with serial frames, checked against a frame-level model
module tb_uart_rx_param;
  logic clk = 1'b0, rst_n = 1'b0, trig = 1'b0;
  logic [2:0] raw = 3'b111, ready = 3'b111;
  logic [7:0] data_a, data_b;
  logic [8:0] data_c;
  logic [2:0] dv, pe, fe, ov;
  int n_chk = 0, n_fail = 0, tc = 0;
  int vcnt [3] = '{0, 0, 0};
  logic [13:0] got [$];
  always #5 clk = ~clk;
  uart_rx_param u_a (
    .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw[0]), .data(data_a), .data_valid(dv[0]),
    .data_ready(ready[0]), .parity_err(pe[0]), .framing_err(fe[0]), .overrun(ov[0]));
  uart_rx_param #(.PARITY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw[1]), .data(data_b), .data_valid(dv[1]),
    .data_ready(ready[1]), .parity_err(pe[1]), .framing_err(fe[1]), .overrun(ov[1]));
  uart_rx_param #(.DATA_BITS(9), .STOP_BITS(2), .OVERSAMPLE(8)) u_c (
    .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw[2]), .data(data_c), .data_valid(dv[2]),
    .data_ready(ready[2]), .parity_err(pe[2]), .framing_err(fe[2]), .overrun(ov[2]));
  initial forever begin
    @(negedge clk);
    tc = (tc + 1) % 4;
    trig = (tc == 0);
  end
  // every word handed over (valid && ready) is logged as {instance, fe, pe, data}
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (dv[i]) vcnt[i]++;
    if (dv[0] && ready[0]) got.push_back({2'd0, fe[0], pe[0], 1'b0, data_a});
    if (dv[1] && ready[1]) got.push_back({2'd1, fe[1], pe[1], 1'b0, data_b});
    if (dv[2] && ready[2]) got.push_back({2'd2, fe[2], pe[2], data_c});
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic drive(input int k, input logic b, input int n);
    @(negedge clk);
    raw[k] = b;
    repeat (n) begin
      @(posedge clk);
      while (!trig) @(posedge clk);
    end
  endtask
  task automatic send_frame(input int k, input int os, input int nb, input logic [8:0] w, input int pbit,
                            input logic sv, input int ns);
    drive(k, 1'b0, os);
    for (int i = 0; i < nb; i++) drive(k, w[i], os);
    if (pbit >= 0) drive(k, pbit[0], os);
    for (int i = 0; i < ns; i++) drive(k, sv, os);
  endtask
  task automatic frame(input int k, input int os, input int nb, input logic [8:0] w, input int pbit, input int ns);
    send_frame(k, os, nb, w, pbit, 1'b1, ns);
    drive(k, 1'b1, 2 * os);
  endtask
  task automatic expect_frame(input string tag, input int k, input logic [8:0] d, input logic p, input logic f);
    logic [13:0] r;
    if (got.size() == 0) check({tag, "_count"}, 32'd0, 32'd1);
    else begin
      r = got.pop_front();
      check(tag, 32'(r), 32'({2'(k), f, p, d}));
    end
  endtask
  initial begin
    logic [8:0] w;
    int p, v;
    #23;
    check("rst_valid", 32'(dv), 32'd0);
    check("rst_flags", 32'({pe, fe, ov}), 32'd0);
    check("rst_data", 32'({data_a, data_b, data_c}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    drive(0, 1'b1, 32);
    v = vcnt[0];
    frame(0, 16, 8, 9'h55, -1, 1);
    expect_frame("a_55", 0, 9'h55, 1'b0, 1'b0);
    check("a_55_valid_len", 32'(vcnt[0] - v), 32'd1);
    for (int i = 0; i < 6; i++) begin
      w = 9'($urandom_range(0, 255));
      frame(0, 16, 8, w, -1, 1);
      expect_frame("a_rand", 0, w, 1'b0, 1'b0);
    end
    frame(1, 16, 8, 9'hA3, 1, 1);
    expect_frame("b_a3_badpar", 1, 9'hA3, 1'b1, 1'b0);
    frame(1, 16, 8, 9'hA3, 0, 1);
    expect_frame("b_a3_goodpar", 1, 9'hA3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = 9'($urandom_range(0, 255));
      p = int'($urandom_range(0, 1));
      frame(1, 16, 8, w, p, 1);
      expect_frame("b_rand", 1, w, ^w[7:0] ^ p[0], 1'b0);
    end
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    check("glitch_none", 32'(got.size()), 32'd0);
    check("glitch_valid", 32'(dv[0]), 32'd0);
    frame(0, 16, 8, 9'h3C, -1, 1);
    expect_frame("a_3c", 0, 9'h3C, 1'b0, 1'b0);
    send_frame(0, 16, 8, 9'h81, -1, 1'b0, 1);
    drive(0, 1'b0, 48);
    expect_frame("a_81_framing", 0, 9'h81, 1'b0, 1'b1);
    check("break_none", 32'(got.size()), 32'd0);
    drive(0, 1'b1, 32);
    frame(0, 16, 8, 9'h42, -1, 1);
    expect_frame("a_42_after_break", 0, 9'h42, 1'b0, 1'b0);
    #1 ready[0] = 1'b0;
    frame(0, 16, 8, 9'h11, -1, 1);
    frame(0, 16, 8, 9'h22, -1, 1);
    @(negedge clk);
    check("ovr_valid", 32'(dv[0]), 32'd1);
    check("ovr_data", 32'(data_a), 32'h11);
    check("ovr_flag", 32'(ov[0]), 32'd1);
    @(posedge clk);
    #1 ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("acc_valid", 32'(dv[0]), 32'd0);
    check("acc_ovr", 32'(ov[0]), 32'd0);
    expect_frame("acc_word", 0, 9'h11, 1'b0, 1'b0);
    check("acc_no_extra", 32'(got.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      w = 9'($urandom_range(0, 511));
      frame(2, 8, 9, w, -1, 2);
      expect_frame("c_rand", 2, w, 1'b0, 1'b0);
    end
    #1 ready[2] = 1'b0;
    frame(2, 8, 9, 9'h1A5, -1, 2);
    @(negedge clk);
    check("c_1a5_valid", 32'(dv[2]), 32'd1);
    check("c_1a5_data", 32'(data_c), 32'h1A5);
    drive(2, 1'b0, 8);
    drive(2, 1'b0, 19);
    #2 rst_n = 1'b0;
    ready[2] = 1'b1;
    #1;
    check("midrst_valid", 32'(dv), 32'd0);
    check("midrst_data", 32'(data_c), 32'd0);
    check("midrst_flags", 32'({pe, fe, ov}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    drive(2, 1'b0, 96);
    check("midrst_none", 32'(got.size()), 32'd0);
    check("midrst_still_idle", 32'(dv[2]), 32'd0);
    drive(2, 1'b1, 32);
    frame(2, 8, 9, 9'h0F3, -1, 2);
    expect_frame("c_0f3_after_rst", 2, 9'h0F3, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL provide DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL provide PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL provide STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 SHALL provide OVERSAMPLE, default 16, sample_trigger pulses per bit period, even, range 8..64.
Ports, one per line: name, direction, width, meaning.
REQ-005 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have sample_trigger, input, 1, one-clk pulse at OVERSAMPLE x bitrate.
REQ-008 SHALL have raw_data, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have data, output, DATA_BITS, received word, LSB received first.
REQ-010 SHALL have data_valid, output, 1, data holds an unread word.
REQ-011 SHALL have data_ready, input, 1, consumer accepts the word when data_valid && data_ready on a clk edge.
REQ-012 SHALL have parity_err, output, 1, parity mismatch for the held word; qualified by data_valid.
REQ-013 SHALL have framing_err, output, 1, a stop bit sampled 0 for the held word; qualified by data_valid.
REQ-014 SHALL have overrun, output, 1, sticky flag: at least one frame was dropped while data_valid was high.

Function
REQ-015 SHALL pass raw_data through a 2-flop synchroniser before any use; the synchronised value is "line" below.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-017 SHALL advance its tick counter (0..OVERSAMPLE-1) only on clk edges with sample_trigger=1.
REQ-018 IDLE: on a trigger with line=0, SHALL go to START with tick=0.
REQ-019 Each bit SHALL be decided by majority vote of line at ticks M-1, M, M+1, where M=OVERSAMPLE/2; the decision is made on the M+1 trigger.
REQ-020 START: a vote of 1 SHALL be treated as a glitch and return to IDLE with no output; a vote of 0 SHALL go to DATA.
REQ-021 DATA SHALL shift DATA_BITS votes LSB-first, then go to PARITY or STOP.
REQ-022 PARITY SHALL flag an error when XOR(data bits, parity bit) is 0 for odd mode or 1 for even mode.
REQ-023 STOP SHALL vote STOP_BITS bits; any stop vote of 0 sets the frame's framing error.
REQ-024 The FSM SHALL return to IDLE on the clk edge of the last stop-bit decision, not at bit end, so it can resync to the next start edge.
REQ-025 On that same edge, with data_valid=0, SHALL load data, parity_err and framing_err and set data_valid=1 (latency 1 clk after the deciding trigger).
REQ-026 On that same edge, with data_valid=1 and no simultaneous accept, SHALL discard the new frame, keep the held word unchanged and set overrun=1.
REQ-027 A completion and an accept on the same edge SHALL load the new word with data_valid staying 1 and SHALL NOT set overrun.
REQ-028 An accept without a completion SHALL clear data_valid on the next edge.
REQ-029 overrun SHALL clear on an accept edge unless REQ-026 sets it on that same edge.
REQ-030 A frame with framing error SHALL still be delivered; after it, the FSM SHALL wait for line=1 before re-arming start detection (break handling).
REQ-031 data, parity_err and framing_err SHALL stay stable while data_valid=1 and no accept occurs.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, tick=0, data=0, data_valid=0, parity_err=0, framing_err=0, overrun=0, and synchroniser flops=1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no output; after release, reception SHALL start on the next falling edge only.

Verification
REQ-034 Defaults, frame 0x55, ready held 1 -> data=0x55, data_valid high for exactly 1 clk, both error flags 0.
REQ-035 PARITY=2, byte 0xA3 sent with parity bit 1 (wrong) -> data=0xA3, parity_err=1; resent with parity bit 0 -> parity_err=0.
REQ-036 Line low for 4 ticks, then high -> no data_valid, FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-037 Frame 0x81 with stop bit 0 and line then held low for 3 bit times -> framing_err=1, no second frame until line returns high.
REQ-038 ready=0, frames 0x11 then 0x22 -> data stays 0x11, overrun=1; accept -> overrun=0, data_valid=0.
REQ-039 DATA_BITS=9, STOP_BITS=2, OVERSAMPLE=8, word 0x1A5 -> data=0x1A5; rst_n pulsed mid-frame -> all outputs 0 and no spurious word.
